// File: rtl/prbs9_checker.sv
`timescale 1ns/1ps
// prbs9_checker: receive-side PRBS9 (x^9 + x^5 + 1) checker.
// Self-synchronises to the incoming bit stream, declares lock, then
// free-runs its LFSR and counts checked bits and bit errors. Too many
// errors inside a window drop it back to searching.
// Optional feature macro: PRBS_STICKY_ERR_EN adds the o_err_sticky output,
// a latched error flag meant for an LED.
module prbs9_checker #(
  parameter int ORDER    = 9,   // only 9 is supported; taps are fixed
  parameter int LOCK_N   = 16,
  parameter int WIN      = 64,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_clear,
  output logic             o_lock,
  output logic             o_err_pulse,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt
`ifdef PRBS_STICKY_ERR_EN
  ,
  output logic             o_err_sticky
`endif
);

  localparam int FILL_W  = $clog2(ORDER + 1);
  localparam int MATCH_W = $clog2(LOCK_N + 1);
  localparam int WIN_W   = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int WEC_W   = $clog2(LOSS_THR + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  logic [8:0]         sr;
  logic [FILL_W-1:0]  fill_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [WEC_W-1:0]   wec_cnt;

  logic               expected_bit;
  logic               bit_err;
  logic [WEC_W-1:0]   wec_next;
  logic [MATCH_W-1:0] match_next;
  logic               count_event;

  // Predict the next bit from history and compare it against the received bit
  always_comb begin
    expected_bit = sr[8] ^ sr[4];
    bit_err      = i_bit ^ expected_bit;
    wec_next     = wec_cnt + WEC_W'(bit_err);
    match_next   = match_cnt + MATCH_W'(1);
    count_event  = i_enable && i_valid && (state == LOCKED);
  end

  // Search/lock state machine with the history register and window tracking
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= SEARCH;
      sr          <= '0;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      win_cnt     <= '0;
      wec_cnt     <= '0;
      o_lock      <= 1'b0;
      o_err_pulse <= 1'b0;
    end else begin
      o_err_pulse <= 1'b0;
      if (!i_enable) begin
        state     <= SEARCH;
        o_lock    <= 1'b0;
        fill_cnt  <= '0;
        match_cnt <= '0;
        win_cnt   <= '0;
        wec_cnt   <= '0;
      end else if (i_valid) begin
        case (state)
          SEARCH: begin
            sr <= {sr[7:0], i_bit};
            if (fill_cnt < FILL_W'(ORDER)) begin
              fill_cnt <= fill_cnt + FILL_W'(1);
            end else if (!bit_err && (sr != '0)) begin
              match_cnt <= match_next;
              if (match_next == MATCH_W'(LOCK_N)) begin
                state   <= LOCKED;
                o_lock  <= 1'b1;
                win_cnt <= '0;
                wec_cnt <= '0;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            sr          <= {sr[7:0], expected_bit};
            o_err_pulse <= bit_err;
            if (wec_next >= WEC_W'(LOSS_THR)) begin
              state     <= SEARCH;
              o_lock    <= 1'b0;
              fill_cnt  <= '0;
              match_cnt <= '0;
              win_cnt   <= '0;
              wec_cnt   <= '0;
            end else if (win_cnt == WIN_W'(WIN - 1)) begin
              win_cnt <= '0;
              wec_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + WIN_W'(1);
              wec_cnt <= wec_next;
            end
          end
          default: begin
            state  <= SEARCH;
            o_lock <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating bit/error counters; once the bit count tops out both freeze
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      o_bit_cnt <= '0;
      o_err_cnt <= '0;
    end else if (i_clear) begin
      o_bit_cnt <= '0;
      o_err_cnt <= '0;
    end else if (count_event && (o_bit_cnt != CNT_MAX)) begin
      o_bit_cnt <= o_bit_cnt + CNT_W'(1);
      if (bit_err && (o_err_cnt != CNT_MAX)) begin
        o_err_cnt <= o_err_cnt + CNT_W'(1);
      end
    end
  end

`ifdef PRBS_STICKY_ERR_EN
  // Latch any error pulse until reset or an explicit clear
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      o_err_sticky <= 1'b0;
    end else if (i_clear) begin
      o_err_sticky <= 1'b0;
    end else if (o_err_pulse) begin
      o_err_sticky <= 1'b1;
    end
  end
`endif

endmodule
